// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction-memory port
// and parks a returned word in a one-entry hold buffer while the pipeline is frozen.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        cpu_stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        fetch_stall_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        hold_valid, hold_valid_next;
    logic [31:0] hold_instr, hold_instr_next;

    logic fetch_ack;
    logic avail;
    logic adv;
    logic pc_change;

    // Acks are only meaningful while a request is open; a stray ack in IDLE is dropped.
    assign fetch_ack = (state == FETCH) && imem_ack_i;
    assign avail     = hold_valid || fetch_ack;
    assign adv       = avail && !cpu_stall_i;
    assign pc_change = adv && (branch_i || !stall_i);

    assign imem_req_o    = (state == FETCH);
    assign imem_addr_o   = pc;
    assign pc_o          = pc;
    assign fetch_stall_o = (state == FETCH) && !imem_ack_i;
    assign instr_o       = hold_valid ? hold_instr
                         : (fetch_ack ? imem_rdata_i : 32'h0000_0000);

    // NOTE: every variable is given its current value first so no path through
    // the case statement leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        hold_valid_next = hold_valid;
        hold_instr_next = hold_instr;

        // Branch wins over the load-use stall; IF/ID flushes the wrong-path word.
        if (adv && branch_i) begin
            pc_next = branch_target_i;
        end else if (adv && !stall_i) begin
            pc_next = pc + PC_STEP;
        end

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack_i && !pc_change) begin
                    state_next      = READY;
                    hold_valid_next = 1'b1;
                    hold_instr_next = imem_rdata_i;
                end
            end
            READY: begin
                if (pc_change) begin
                    state_next      = FETCH;
                    hold_valid_next = 1'b0;
                end
            end
            default: begin
                state_next      = IDLE;
                hold_valid_next = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            hold_valid <= 1'b0;
            hold_instr <= 32'h0000_0000;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            hold_valid <= hold_valid_next;
            hold_instr <= hold_instr_next;
        end
    end

endmodule
